cr_receiver_demux: RTL and testbench
====================================

# cr_receiver_demux

Receive-side companion to the three-channel cognitive-radio transmit controller. Each cycle it takes one serial bit slot per channel: a licensed-line bit, two unlicensed-line bits and that channel's occupancy bit. It rebuilds per-channel frames of `d_len` bits: the licensed word with a presence mask, plus the two unlicensed words (A, B). When a licensed slot was vacant, the unlicensed-B bit is recovered from the licensed line. Completed frames leave through a valid/ready output register with backpressure to the serial side.

## Interface
- `d_len`, default 32: frame length in bit slots; also the width of every recovered word. Legal range 2..256.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the slot bits below are valid this cycle.
- `in_ready` output 1: the block accepts a slot this cycle. A slot transfers when `in_valid && in_ready`.
- `sync` input 1: frame realignment; discards any partial or pending frame.
- `d` input 3: occupancy per channel; bit c = 1 means the licensed slot carries licensed data.
- `l_bit` input 3: licensed-line bit, channel c at bit c.
- `ua_bit` input 3: unlicensed-A line bit.
- `ub_bit` input 3: unlicensed-B line bit, meaningful only when d[c] = 1.
- `out_valid` output 1: output frame registers hold an unconsumed frame.
- `out_ready` input 1: consumer takes the frame when `out_valid && out_ready`.
- `l_word` output 3*d_len: licensed words; channel c occupies [c*d_len +: d_len].
- `l_mask` output 3*d_len: per-bit licensed presence, copied from d[c] per slot.
- `ua_word` output 3*d_len: unlicensed-A words.
- `ub_word` output 3*d_len: unlicensed-B words.
- `lic_cnt` output 3*(clog2(d_len+1)): per channel, the number of d=1 slots in the frame.
- `frame_cnt` output 16: frames delivered (handshakes on out side), wraps at 2^16.

## Operation
- Slot index `cnt` runs 0..d_len-1, LSB first: slot k writes bit k of each accumulator.
- Per channel c on an accepted slot:
  - d[c]=1: acc_l[k]=l_bit[c], acc_m[k]=1, acc_a[k]=ua_bit[c], acc_b[k]=ub_bit[c].
  - d[c]=0: acc_l[k]=0, acc_m[k]=0, acc_a[k]=ua_bit[c], acc_b[k]=l_bit[c]. ub_bit[c] is ignored.
- The per-channel occupancy counters increment on each accepted d[c]=1 slot and reset to 0 at frame start.
- State COLLECT (`in_ready`=1):
  - Accepted slot with cnt<d_len-1: cnt+1.
  - Accepted slot with cnt=d_len-1: the frame is complete. If `!out_valid || out_ready`, the frame (including the final bit) loads into the output registers, `out_valid`<=1, cnt<=0, and the state stays COLLECT. Otherwise the state goes to FULL with cnt<=0, and the accumulators hold the frame.
- State FULL (`in_ready`=0):
  - When `out_ready` is sampled high, the output registers load from the accumulators, `out_valid` stays 1, and the state goes to COLLECT.
- Out-side handshake without a new load: `out_valid`<=0. Output data stays stable while `out_valid && !out_ready`.
- `frame_cnt` increments on every out-side handshake.
- `sync`=1 (highest synchronous priority):
  - cnt<=0; accumulators and occupancy counters cleared; state<=COLLECT.
  - A slot presented in the same cycle is dropped.
  - The output registers, `out_valid` and `frame_cnt` are untouched, so the out-side handshake in that cycle still completes.
- Reset: state COLLECT, cnt 0, all accumulators 0. All outputs 0 except `in_ready`=1.

## Timing
- `in_ready` is a function of state only: high in COLLECT, low in FULL. There is no combinational path from `out_ready`.
- Latency: `out_valid` rises the cycle after the final slot is accepted.
- Throughput: one slot per cycle; back-to-back frames need no bubble while `out_ready` is held high.
- At most one complete frame is buffered behind the output register. With `out_ready` low, at most one further frame (d_len slots) is absorbed before `in_ready` drops.
- FULL to COLLECT takes one cycle after `out_ready` is sampled. `in_ready` is high again in the next cycle.
- Asserting `rst_n` low mid-frame clears everything immediately, without waiting for a clock edge. The first slot after deassertion is slot 0.
- `frame_cnt` wraps from 16'hFFFF to 0 with no flag.

## Test plan
- d_len=8, d=3'b111 every slot, l_bit/ua_bit/ub_bit driven so channel 0 yields l=0xA5, a=0x3C, b=0x0F with out_ready=1 -> `out_valid` 1 cycle after slot 7; l_mask[7:0]=0xFF; lic_cnt ch0=8; frame_cnt=1.
- d=3'b000, l_bit[0] stream 0x5A, ua_bit[0] stream 0xC3 -> ub_word ch0=0x5A, ua_word ch0=0xC3, l_word ch0=0, l_mask ch0=0, lic_cnt ch0=0.
- d[1] alternating 1,0 from slot 0 -> l_mask ch1=0x55; lic_cnt ch1=4; l_word ch1 bits 1,3,5,7 = 0; ub bits at odd slots taken from l_bit[1].
- out_ready=0, three frames offered continuously -> frame 1 in output registers, frame 2 in FULL, `in_ready`=0 from the cycle after frame 2 slot 7. out_ready pulsed once -> frame 2 presented, `in_ready` high next cycle. Frame 3 then completes intact with no data loss.
- sync at slot 4 of a frame -> the next 8 accepted slots form one complete frame; the pre-sync bits never appear; frame_cnt is unchanged by the sync.
- rst_n low at slot 5 with out_valid=1 -> all outputs 0 immediately, in_ready=1; the first post-reset frame decodes correctly and frame_cnt=1.

Source files
------------

// File: rtl/cr_receiver_demux.sv
`default_nettype none
// ============================================================================
// Module   : cr_receiver_demux
// Purpose  : Three-channel cognitive-radio receive demux. Rebuilds licensed,
//            unlicensed-A and unlicensed-B words per channel from serial
//            slots and hands frames out through a valid/ready register.
// Revision : 1.0 - initial release
// ============================================================================
module cr_receiver_demux #(
    parameter int d_len = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               sync,
    input  logic [2:0]                         d,
    input  logic [2:0]                         l_bit,
    input  logic [2:0]                         ua_bit,
    input  logic [2:0]                         ub_bit,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [3*d_len-1:0]                 l_word,
    output logic [3*d_len-1:0]                 l_mask,
    output logic [3*d_len-1:0]                 ua_word,
    output logic [3*d_len-1:0]                 ub_word,
    output logic [3*($clog2(d_len+1))-1:0]     lic_cnt,
    output logic [15:0]                        frame_cnt
);

    localparam int c_cw = $clog2(d_len);
    localparam int c_lw = $clog2(d_len + 1);

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic            r_out_valid;
    logic [15:0]     r_frame_cnt;

    logic w_accept;
    logic w_last;
    logic w_room;
    logic w_load;
    logic w_hs;

    assign in_ready  = (r_state == S_COLLECT);
    assign w_accept  = in_valid && in_ready && !sync;
    assign w_last    = (r_cnt == c_cw'(d_len - 1));
    assign w_room    = !r_out_valid || out_ready;
    assign w_hs      = r_out_valid && out_ready;
    // In FULL no slot is accepted, so the next-accumulator view equals the
    // held frame and one load path serves both cases.
    assign w_load    = !sync && ((w_accept && w_last && w_room) ||
                                 ((r_state == S_FULL) && out_ready));
    assign out_valid = r_out_valid;
    assign frame_cnt = r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sync) begin
            w_state_nxt = S_COLLECT;
        end else begin
            case (r_state)
                S_COLLECT: if (w_accept && w_last && !w_room) w_state_nxt = S_FULL;
                S_FULL:    if (out_ready) w_state_nxt = S_COLLECT;
                default:   w_state_nxt = S_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (sync) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_hs) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [d_len-1:0] r_acc_l, r_acc_m, r_acc_a, r_acc_b;
        logic [d_len-1:0] w_nxt_l, w_nxt_m, w_nxt_a, w_nxt_b;
        logic [d_len-1:0] r_out_l, r_out_m, r_out_a, r_out_b;
        logic [c_lw-1:0]  r_acc_n, w_nxt_n, r_out_n;

        always_comb begin
            w_nxt_l = r_acc_l;
            w_nxt_m = r_acc_m;
            w_nxt_a = r_acc_a;
            w_nxt_b = r_acc_b;
            w_nxt_n = r_acc_n;
            if (w_accept) begin
                w_nxt_l[r_cnt] = d[c] & l_bit[c];
                w_nxt_m[r_cnt] = d[c];
                w_nxt_a[r_cnt] = ua_bit[c];
                // A vacant licensed slot carries the unlicensed-B bit.
                w_nxt_b[r_cnt] = d[c] ? ub_bit[c] : l_bit[c];
                w_nxt_n        = ((r_cnt == '0) ? '0 : r_acc_n) + c_lw'(d[c]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc_l <= '0;
                r_acc_m <= '0;
                r_acc_a <= '0;
                r_acc_b <= '0;
                r_acc_n <= '0;
                r_out_l <= '0;
                r_out_m <= '0;
                r_out_a <= '0;
                r_out_b <= '0;
                r_out_n <= '0;
            end else begin
                if (sync) begin
                    r_acc_l <= '0;
                    r_acc_m <= '0;
                    r_acc_a <= '0;
                    r_acc_b <= '0;
                    r_acc_n <= '0;
                end else begin
                    r_acc_l <= w_nxt_l;
                    r_acc_m <= w_nxt_m;
                    r_acc_a <= w_nxt_a;
                    r_acc_b <= w_nxt_b;
                    r_acc_n <= w_nxt_n;
                end
                if (w_load) begin
                    r_out_l <= w_nxt_l;
                    r_out_m <= w_nxt_m;
                    r_out_a <= w_nxt_a;
                    r_out_b <= w_nxt_b;
                    r_out_n <= w_nxt_n;
                end
            end
        end

        assign l_word [c*d_len +: d_len] = r_out_l;
        assign l_mask [c*d_len +: d_len] = r_out_m;
        assign ua_word[c*d_len +: d_len] = r_out_a;
        assign ub_word[c*d_len +: d_len] = r_out_b;
        assign lic_cnt[c*c_lw  +: c_lw ] = r_out_n;
    end

endmodule
`default_nettype wire

// File: tb/tb_cr_receiver_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_receiver_demux
// Purpose  : Directed scoreboard bench for cr_receiver_demux with d_len = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_receiver_demux;

    localparam int DL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sync, out_valid, out_ready;
    logic [2:0]  d, l_bit, ua_bit, ub_bit;
    logic [23:0] l_word, l_mask, ua_word, ub_word;
    logic [11:0] lic_cnt;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] m;
        logic [23:0] a;
        logic [23:0] b;
        logic [11:0] n;
    } frame_t;

    frame_t q[$];
    int     checks   = 0;
    int     failures = 0;
    logic [15:0] exp_fc = '0;

    cr_receiver_demux #(.d_len(DL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sync(sync), .d(d), .l_bit(l_bit), .ua_bit(ua_bit), .ub_bit(ub_bit),
        .out_valid(out_valid), .out_ready(out_ready), .l_word(l_word),
        .l_mask(l_mask), .ua_word(ua_word), .ub_word(ub_word),
        .lic_cnt(lic_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=progress", tag);
    endtask

    // Output-side scoreboard: each handshake pops and compares one frame.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                timeout("unexpected_frame");
            end else begin
                frame_t e;
                e = q.pop_front();
                chk("l_word",  {40'd0, l_word},  {40'd0, e.l});
                chk("l_mask",  {40'd0, l_mask},  {40'd0, e.m});
                chk("ua_word", {40'd0, ua_word}, {40'd0, e.a});
                chk("ub_word", {40'd0, ub_word}, {40'd0, e.b});
                chk("lic_cnt", {52'd0, lic_cnt}, {52'd0, e.n});
            end
            exp_fc = exp_fc + 16'd1;
        end
    end

    task automatic slot(input logic [2:0] dd, ll, aa, bb);
        in_valid = 1'b1; d = dd; l_bit = ll; ua_bit = aa; ub_bit = bb;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        timeout("slot_accept");
    endtask

    task automatic send_frame(input logic [2:0][7:0] dw, lw, aw, bw);
        frame_t e;
        for (int k = 0; k < DL; k++)
            slot({dw[2][k], dw[1][k], dw[0][k]}, {lw[2][k], lw[1][k], lw[0][k]},
                 {aw[2][k], aw[1][k], aw[0][k]}, {bw[2][k], bw[1][k], bw[0][k]});
        for (int c = 0; c < 3; c++) begin
            e.l[c*8 +: 8] = lw[c] & dw[c];
            e.m[c*8 +: 8] = dw[c];
            e.a[c*8 +: 8] = aw[c];
            e.b[c*8 +: 8] = (bw[c] & dw[c]) | (lw[c] & ~dw[c]);
            e.n[c*4 +: 4] = 4'($countones(dw[c]));
        end
        q.push_back(e);
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (q.size() == 0) return;
            @(posedge clk); #1;
        end
        timeout("drain");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
        d = '0; l_bit = '0; ua_bit = '0; ub_bit = '0;
        #3;
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_l_word",    {40'd0, l_word}, 64'd0);
        chk("rst_ub_word",   {40'd0, ub_word}, 64'd0);
        chk("rst_lic_cnt",   {52'd0, lic_cnt}, 64'd0);
        chk("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // All slots occupied; latency check right after the final slot edge.
        send_frame({8'hFF, 8'hFF, 8'hFF}, {8'h9A, 8'h12, 8'hA5},
                   {8'hBC, 8'h34, 8'h3C}, {8'hDE, 8'h56, 8'h0F});
        chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
        drain();
        chk("frame_cnt_1", {48'd0, frame_cnt}, 64'd1);

        // Vacant slots, then alternating occupancy, back to back.
        send_frame({8'h00, 8'h00, 8'h00}, {8'h77, 8'h11, 8'h5A},
                   {8'h88, 8'h22, 8'hC3}, {8'h99, 8'h33, 8'hFF});
        send_frame({8'h0F, 8'h55, 8'hF0}, {8'h3C, 8'hFF, 8'h69},
                   {8'hE1, 8'h0D, 8'h42}, {8'hA7, 8'h00, 8'hB4});
        drain();
        chk("frame_cnt_3", {48'd0, frame_cnt}, {48'd0, exp_fc});

        // Backpressure: one frame in the output register, one held in FULL.
        out_ready = 1'b0;
        send_frame({8'hC3, 8'h3C, 8'hAA}, {8'h01, 8'h02, 8'h03},
                   {8'h04, 8'h05, 8'h06}, {8'h07, 8'h08, 8'h09});
        send_frame({8'hF0, 8'h0F, 8'h55}, {8'hFE, 8'hDC, 8'hBA},
                   {8'h98, 8'h76, 8'h54}, {8'h32, 8'h10, 8'hEF});
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_out_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("release_out_valid", {63'd0, out_valid}, 64'd1);
        send_frame({8'h81, 8'h18, 8'hE7}, {8'h5F, 8'hA0, 8'h3E},
                   {8'hC1, 8'h7B, 8'h2D}, {8'h96, 8'h4E, 8'hD8});
        chk("full2_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        drain();
        chk("frame_cnt_bp", {48'd0, frame_cnt}, {48'd0, exp_fc});

        // Realignment mid-frame: the four pre-sync slots must vanish.
        for (int k = 0; k < 4; k++) slot(3'b111, 3'b111, 3'b111, 3'b111);
        sync = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0; in_valid = 1'b0;
        chk("sync_frame_cnt", {48'd0, frame_cnt}, {48'd0, exp_fc});
        send_frame({8'h33, 8'hCC, 8'h5A}, {8'h00, 8'h00, 8'h00},
                   {8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00});
        drain();

        // Asynchronous reset mid-frame with a frame pending at the output.
        out_ready = 1'b0;
        send_frame({8'hFF, 8'hFF, 8'hFF}, {8'h11, 8'h22, 8'h33},
                   {8'h44, 8'h55, 8'h66}, {8'h77, 8'h88, 8'h99});
        for (int k = 0; k < 5; k++) slot(3'b101, 3'b011, 3'b110, 3'b111);
        rst_n = 1'b0;
        #2;
        q.delete();
        exp_fc = '0;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("arst_l_word",    {40'd0, l_word}, 64'd0);
        chk("arst_l_mask",    {40'd0, l_mask}, 64'd0);
        chk("arst_lic_cnt",   {52'd0, lic_cnt}, 64'd0);
        chk("arst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_frame({8'h6C, 8'hB2, 8'h1D}, {8'hF3, 8'h4A, 8'h8E},
                   {8'h27, 8'hD5, 8'h90}, {8'h5B, 8'hC6, 8'h3F});
        drain();
        chk("post_rst_frame_cnt", {48'd0, frame_cnt}, 64'd1);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
